// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing a - b - bin, LSB first, one bit per clock.
//   A single full-subtractor cell with a registered borrow walks the operand shift registers.
//   The start/done handshake lets a controller issue back-to-back operations with no idle cycle.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only when not busy (IDLE or DONE)
//   a      in   [WIDTH] minuend, captured on accepted start
//   b      in   [WIDTH] subtrahend, captured on accepted start
//   bin    in   borrow-in, captured on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse; diff/bout valid from this cycle
//   diff   out  [WIDTH] (a - b - bin) mod 2^WIDTH, held until the next completion
//   bout   out  final borrow-out (1 when a < b + bin, unsigned)

module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic             d;
    logic             br_next;
    logic             last;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs plus the result shift-in.
    always_comb begin
        d                 = a_q[0] ^ b_q[0] ^ br_q;
        br_next           = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_next          = res_q >> 1;
        res_next[WIDTH-1] = d;
        last              = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                // DONE accepts start exactly like IDLE so operations can run back to back.
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    br_q  <= br_next;
                    res_q <= res_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last) begin
                        diff_q  <= res_next;
                        bout_q  <= br_next;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing A - B - Bin, LSB-first, one bit per clock.
- Built around a single full-subtractor cell with a registered borrow, the counterpart of the team's full-adder cell.
- Used where area matters more than latency; sits beside the adder datapath and is driven by a controller through a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only when not busy
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
bin    input   1      borrow-in, captured on accepted start
busy   output  1      high while bits are being processed
done   output  1      one-cycle pulse; diff/bout valid from this cycle
diff   output  WIDTH  result A - B - Bin modulo 2^WIDTH
bout   output  1      final borrow-out (1 when A < B + Bin, unsigned)

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, borrow reg=0, shift regs=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - on an edge with start=1: load a/b into shift regs, borrow reg<=bin, counter<=0, go to RUN, busy<=1.
  - start=0: stay in IDLE.
- RUN: each edge processes bit0 of the shift regs:
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the MSB of the result shift reg; a/b shift right; counter increments.
- Completion: on the edge where counter = WIDTH-1:
  - diff<=final result, bout<=br_next, done<=1, busy<=0, go to DONE.
- Latency: if start is accepted at edge E0, done is high in the cycle after edge E(WIDTH). The result is valid exactly WIDTH edges after acceptance.
- DONE: lasts one cycle; done returns to 0 on the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back ops, no bubble).
  - Otherwise go to IDLE.
- start while busy=1 (RUN) is ignored; a/b/bin changes during RUN have no effect.
- diff/bout change only at completion; they hold the last result through IDLE and the next RUN until the next completion.
- WIDTH=1: RUN lasts one edge; done follows the accepting edge by exactly one edge.
- Arithmetic: unsigned modulo 2^WIDTH. bout equals bit WIDTH of the (WIDTH+1)-bit value {0,A} - {0,B} - Bin, i.e. the borrow.
- Reset asserted mid-RUN aborts the operation: all outputs go to reset values immediately (asynchronously); no done pulse is produced. After rst_n deasserts, the block is in IDLE and accepts start on the first edge.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, bin=0, start for one cycle -> busy high for 8 cycles; done pulses exactly 8 edges after acceptance; diff=0x37, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1; a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
- During RUN, pulse start with a=0x11, b=0x01 -> ignored; result still matches the first operands; only one done pulse.
- start held high in the DONE cycle with a=0x10, b=0x03 -> second op accepted without an idle cycle; done again 8 edges later, diff=0x0D; diff holds the previous value until then.
- rst_n pulsed low mid-RUN (after 3 bits) -> diff=0, bout=0, busy=0 immediately; no done; a new start after release gives the correct result.
- Random sweep: 1000 random a/b/bin for WIDTH=8 and WIDTH=1 -> diff and bout match the reference model (A - B - Bin) every operation.
